// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage and the IF/ID register:
//   - INSTR_W          : instruction / address width (32)
//   - RESET_PC_DEFAULT : first fetch address after reset
//   - fetch_state_e    : fetch FSM state encodings
//   - word_align()     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

   // Instructions are word aligned, so redirect targets drop bits [1:0].
   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
      return {addr[INSTR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register with load / hold / invalidate controls.
// The decode stage reuses this same interface.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   load             : capture instr_in / pc_plus4_in and mark valid
//   invalidate       : clear valid, leave the payload untouched
//   instr_in         : instruction word to capture
//   pc_plus4_in      : fetch address + 4 to capture
//   valid            : register holds a real instruction
//   instr            : registered instruction
//   pc_plus4         : registered fetch address + 4
// Neither control asserted means hold.
// ---------------------------------------------------------------------------
module ifid_reg
   import fetch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               invalidate,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [INSTR_W-1:0] pc_plus4_in,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] pc_plus4
);

   logic               valid_q,    valid_d;
   logic [INSTR_W-1:0] instr_q,    instr_d;
   logic [INSTR_W-1:0] pc_plus4_q, pc_plus4_d;

   // Next-value selection: a load wins over invalidate, otherwise hold.
   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      if (load) begin
         valid_d    = 1'b1;
         instr_d    = instr_in;
         pc_plus4_d = pc_plus4_in;
      end else if (invalidate) begin
         valid_d    = 1'b0;
      end
   end

   // Register storage, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_plus4_q <= '0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, runs a req/ready handshake with
// instruction memory and feeds the IF/ID register.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   stall                 : hold IF/ID, no handoff while high
//   redirect_valid/_pc    : jump / jal / jr / taken-branch target
//   halt                  : syscall seen, stop fetching
//   imem_req/_addr        : memory request and its address
//   imem_ready/_rdata     : memory response (completes the request)
//   ifid_valid/_instr/_pc_plus4 : IF/ID register contents
//   misalign              : sticky, a redirect target was not word aligned
// Priority every cycle: halt > redirect_valid > stall.
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [INSTR_W-1:0] redirect_pc,
   input  logic               halt,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [INSTR_W-1:0] ifid_pc_plus4,
   output logic               misalign
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
   logic [INSTR_W-1:0] hold_pc_plus4_q, hold_pc_plus4_d;
   logic               halt_pend_q, halt_pend_d;
   logic               misalign_q, misalign_d;

   logic               ifid_load;
   logic               ifid_inval;
   logic [INSTR_W-1:0] ifid_instr_in;
   logic [INSTR_W-1:0] ifid_pc_plus4_in;
   logic [INSTR_W-1:0] fetch_addr_plus4;
   logic               launch;
   logic               take_redirect;

   assign fetch_addr_plus4 = fetch_addr_q + 32'd4;

   // State register together with the PC and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_REQ;
         pc_q            <= RESET_PC;
         fetch_addr_q    <= RESET_PC;
         hold_instr_q    <= '0;
         hold_pc_plus4_q <= '0;
         halt_pend_q     <= 1'b0;
         misalign_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         fetch_addr_q    <= fetch_addr_d;
         hold_instr_q    <= hold_instr_d;
         hold_pc_plus4_q <= hold_pc_plus4_d;
         halt_pend_q     <= halt_pend_d;
         misalign_q      <= misalign_d;
      end
   end

   // Next-state and datapath decisions. "launch" marks the cycles where a
   // fresh request starts next cycle; only then does fetch_addr pick up the
   // new PC, which keeps imem_addr stable across a pending request.
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      fetch_addr_d     = fetch_addr_q;
      hold_instr_d     = hold_instr_q;
      hold_pc_plus4_d  = hold_pc_plus4_q;
      halt_pend_d      = halt_pend_q;
      misalign_d       = misalign_q;
      ifid_load        = 1'b0;
      ifid_inval       = 1'b0;
      ifid_instr_in    = imem_rdata;
      ifid_pc_plus4_in = fetch_addr_plus4;
      launch           = 1'b0;
      take_redirect    = 1'b0;

      case (state_q)
         ST_REQ: begin
            if (imem_ready) begin
               if (halt) begin
                  ifid_inval = 1'b1;
                  state_d    = ST_HALTED;
               end else if (redirect_valid) begin
                  take_redirect = 1'b1;
                  ifid_inval    = 1'b1;
                  launch        = 1'b1;
               end else if (stall) begin
                  hold_instr_d    = imem_rdata;
                  hold_pc_plus4_d = fetch_addr_plus4;
                  pc_d            = fetch_addr_plus4;
                  state_d         = ST_HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = fetch_addr_plus4;
                  launch    = 1'b1;
               end
            end else begin
               if (halt) begin
                  halt_pend_d = 1'b1;
                  ifid_inval  = 1'b1;
                  state_d     = ST_DRAIN;
               end else if (redirect_valid) begin
                  take_redirect = 1'b1;
                  ifid_inval    = 1'b1;
                  state_d       = ST_DRAIN;
               end else if (!stall) begin
                  ifid_inval = 1'b1;
               end
            end
         end

         ST_HOLD: begin
            if (halt) begin
               ifid_inval = 1'b1;
               state_d    = ST_HALTED;
            end else if (redirect_valid) begin
               take_redirect = 1'b1;
               ifid_inval    = 1'b1;
               launch        = 1'b1;
               state_d       = ST_REQ;
            end else if (!stall) begin
               ifid_load        = 1'b1;
               ifid_instr_in    = hold_instr_q;
               ifid_pc_plus4_in = hold_pc_plus4_q;
               launch           = 1'b1;
               state_d          = ST_REQ;
            end
         end

         ST_DRAIN: begin
            // The outstanding word is thrown away; only the handshake matters.
            ifid_inval = 1'b1;
            if (halt) begin
               halt_pend_d = 1'b1;
            end else if (redirect_valid) begin
               take_redirect = 1'b1;
            end
            if (imem_ready) begin
               halt_pend_d = 1'b0;
               if (halt_pend_q || halt) begin
                  state_d = ST_HALTED;
               end else begin
                  launch  = 1'b1;
                  state_d = ST_REQ;
               end
            end
         end

         ST_HALTED: begin
            ifid_inval = 1'b1;
         end

         default: begin
            state_d = ST_HALTED;
         end
      endcase

      if (take_redirect) begin
         pc_d       = word_align(redirect_pc);
         misalign_d = misalign_q | (|redirect_pc[1:0]);
      end

      if (launch) begin
         fetch_addr_d = pc_d;
      end
   end

   // Outputs decoded from the state: a request is live in REQ and DRAIN.
   always_comb begin
      imem_req = 1'b0;
      case (state_q)
         ST_REQ, ST_DRAIN: imem_req = 1'b1;
         default:          imem_req = 1'b0;
      endcase
   end

   assign imem_addr = fetch_addr_q;
   assign misalign  = misalign_q;

   ifid_reg u_ifid_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (ifid_load),
      .invalidate  (ifid_inval),
      .instr_in    (ifid_instr_in),
      .pc_plus4_in (ifid_pc_plus4_in),
      .valid       (ifid_valid),
      .instr       (ifid_instr),
      .pc_plus4    (ifid_pc_plus4)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Each scenario task drives memory
// responses cycle by cycle, pushes the IF/ID contents it expects into a
// scoreboard queue, and pops/compares when the handoff should be visible.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        misalign;

   int  checks;
   int  errors;
   sb_t sb_q[$];
   sb_t exp;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .misalign       (misalign)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents are tagged with their own address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      imem_ready     = 1'b0;
      imem_rdata     = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         errors++;
         $display("[TB] FAIL reset_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, RST_PC);
      end
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_ifid: valid=%b instr=%h pc4=%h, expected 0/0/0", ifid_valid, ifid_instr, ifid_pc_plus4);
      end
      checks++;
      if (misalign !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_misalign: got %b expected 0", misalign);
      end
      rst_n = 1'b1;
      sb_q.delete();
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = RST_PC + 32'(4 * i);
         checks++;
         if (imem_addr !== a || imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zw_addr%0d: addr=%h req=%b expected addr=%h req=1", i, imem_addr, imem_req, a);
         end
         imem_ready = 1'b1;
         imem_rdata = word_at(a);
         sb_q.push_back('{instr: word_at(a), pc4: a + 32'd4});
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (ifid_valid !== 1'b1 || ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
            errors++;
            $display("[TB] FAIL zw_ifid%0d: v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                     i, ifid_valid, ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
         end
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_wait_states();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_addr !== RST_PC || imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ws_addr%0d: addr=%h req=%b expected addr=%h req=1", i, imem_addr, imem_req, RST_PC);
         end
         imem_ready = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         tick();
         checks++;
         if (ifid_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ws_bubble%0d: valid=%b expected 0", i, ifid_valid);
         end
      end
      checks++;
      if (imem_addr !== RST_PC) begin
         errors++;
         $display("[TB] FAIL ws_addr3: addr=%h expected %h", imem_addr, RST_PC);
      end
      imem_ready = 1'b1;
      imem_rdata = word_at(RST_PC);
      sb_q.push_back('{instr: word_at(RST_PC), pc4: RST_PC + 32'd4});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
         errors++;
         $display("[TB] FAIL ws_capture: v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                  ifid_valid, ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_stall_hold();
      do_reset();
      imem_ready = 1'b1;
      imem_rdata = word_at(RST_PC);
      sb_q.push_back('{instr: word_at(RST_PC), pc4: RST_PC + 32'd4});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
         errors++;
         $display("[TB] FAIL st_first: instr=%h pc4=%h expected %h/%h", ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
      end
      // Ready edge of 0x00400004 with stall high.
      checks++;
      if (imem_addr !== RST_PC + 32'd4) begin
         errors++;
         $display("[TB] FAIL st_addr: addr=%h expected %h", imem_addr, RST_PC + 32'd4);
      end
      imem_rdata = word_at(RST_PC + 32'd4);
      stall      = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== word_at(RST_PC) ||
             ifid_pc_plus4 !== RST_PC + 32'd4) begin
            errors++;
            $display("[TB] FAIL st_hold%0d: req=%b v=%b instr=%h pc4=%h expected req=0 v=1 instr=%h pc4=%h",
                     i, imem_req, ifid_valid, ifid_instr, ifid_pc_plus4, word_at(RST_PC), RST_PC + 32'd4);
         end
         // A stray response while holding must be ignored.
         imem_ready = 1'b1;
         imem_rdata = 32'hBAD0_BAD0;
         stall      = (i == 0);
         if (i == 1) begin
            imem_ready = 1'b0;
            sb_q.push_back('{instr: word_at(RST_PC + 32'd4), pc4: RST_PC + 32'd8});
         end
         tick();
      end
      exp = sb_q.pop_front();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
         errors++;
         $display("[TB] FAIL st_release: v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                  ifid_valid, ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd8) begin
         errors++;
         $display("[TB] FAIL st_next_addr: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RST_PC + 32'd8);
      end
   endtask

   // Runs straight after test_stall_hold with a request to 0x00400008 open.
   task automatic test_redirect_drain();
      imem_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0080;
      tick();
      // Second redirect while draining; the last one must win.
      redirect_pc    = 32'h0040_0100;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd8 || ifid_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_drain%0d: req=%b addr=%h v=%b expected req=1 addr=%h v=0",
                     i, imem_req, imem_addr, ifid_valid, RST_PC + 32'd8);
         end
         tick();
         redirect_valid = 1'b0;
      end
      checks++;
      if (imem_addr !== RST_PC + 32'd8) begin
         errors++;
         $display("[TB] FAIL rd_drain_hold: addr=%h expected %h", imem_addr, RST_PC + 32'd8);
      end
      imem_ready = 1'b1;
      imem_rdata = word_at(RST_PC + 32'd8);
      tick();
      checks++;
      if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
         errors++;
         $display("[TB] FAIL rd_relaunch: v=%b req=%b addr=%h expected v=0 req=1 addr=00400100",
                  ifid_valid, imem_req, imem_addr);
      end
      imem_rdata = word_at(32'h0040_0100);
      sb_q.push_back('{instr: word_at(32'h0040_0100), pc4: 32'h0040_0104});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
         errors++;
         $display("[TB] FAIL rd_target: v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                  ifid_valid, ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
      end
   endtask

   task automatic test_misalign();
      checks++;
      if (misalign !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ma_pre: got %b expected 0", misalign);
      end
      imem_ready     = 1'b1;
      imem_rdata     = 32'hBAD1_BAD1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0102;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (misalign !== 1'b1 || imem_addr !== 32'h0040_0100 || ifid_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ma_set: misalign=%b addr=%h v=%b expected 1/00400100/0", misalign, imem_addr, ifid_valid);
      end
      imem_rdata = word_at(32'h0040_0100);
      sb_q.push_back('{instr: word_at(32'h0040_0100), pc4: 32'h0040_0104});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4 || misalign !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ma_sticky: instr=%h pc4=%h misalign=%b expected %h/%h/1",
                  ifid_instr, ifid_pc_plus4, misalign, exp.instr, exp.pc4);
      end
   endtask

   task automatic test_halt();
      imem_ready = 1'b1;
      imem_rdata = word_at(imem_addr);
      halt       = 1'b1;
      tick();
      halt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ht_halted%0d: req=%b v=%b expected 0/0", i, imem_req, ifid_valid);
         end
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0040_0200;
         stall          = i[0];
         tick();
      end
      clear_inputs();
      // Asynchronous reset pulse, asserted away from the clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC || ifid_valid !== 1'b0 || misalign !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ht_async_rst: req=%b addr=%h v=%b misalign=%b expected 1/%h/0/0",
                  imem_req, imem_addr, ifid_valid, misalign, RST_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      imem_ready = 1'b1;
      imem_rdata = word_at(RST_PC);
      sb_q.push_back('{instr: word_at(RST_PC), pc4: RST_PC + 32'd4});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4) begin
         errors++;
         $display("[TB] FAIL ht_resume: v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=%h",
                  ifid_valid, ifid_instr, ifid_pc_plus4, exp.instr, exp.pc4);
      end
      imem_ready = 1'b0;
   endtask

   task automatic test_halt_pending();
      do_reset();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC || ifid_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hp_drain: req=%b addr=%h v=%b expected 1/%h/0", imem_req, imem_addr, ifid_valid, RST_PC);
      end
      imem_ready = 1'b1;
      imem_rdata = word_at(RST_PC);
      tick();
      imem_ready = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hp_halted: req=%b v=%b expected 0/0", imem_req, ifid_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0202;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (misalign !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hp_ignore_redirect: misalign=%b req=%b expected 0/0", misalign, imem_req);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      imem_ready     = 1'b1;
      imem_rdata     = 32'hBAD2_BAD2;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("[TB] FAIL wr_addr: addr=%h expected fffffffc", imem_addr);
      end
      imem_rdata = word_at(32'hFFFF_FFFC);
      sb_q.push_back('{instr: word_at(32'hFFFF_FFFC), pc4: 32'h0000_0000});
      tick();
      exp = sb_q.pop_front();
      checks++;
      if (ifid_instr !== exp.instr || ifid_pc_plus4 !== exp.pc4 || imem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL wr_wrap: instr=%h pc4=%h addr=%h expected %h/%h/00000000",
                  ifid_instr, ifid_pc_plus4, imem_addr, exp.instr, exp.pc4);
      end
      imem_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear_inputs();
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_redirect_drain();
      test_misalign();
      test_halt();
      test_halt_pending();
      test_wrap();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_empty: %0d entries left, expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of decode/control.
- Owns the PC and runs a request/ready handshake to instruction memory.
- Drives the IF/ID pipeline register, whose instr[31:26] and instr[5:0] feed the control decoder's opcode and funcCode.
- Accepts redirects from jump, jal, jr and branch resolution, a stall from the hazard logic, and a halt from syscall decode.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- stall  in  1  hold IF/ID; no handoff while high.
- redirect_valid  in  1  take redirect_pc as the next fetch PC.
- redirect_pc  in  32  target of a jump, jal, jr or taken branch.
- halt  in  1  syscall seen; stop fetching.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; stable while imem_req is high and imem_ready is low.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc_plus4  out  32  fetch address + 4.
- misalign  out  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, fetch_addr=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, misalign=0, hold buffer=0.
- imem_req is combinational: 1 in REQ and DRAIN, 0 otherwise.
- imem_addr = fetch_addr register. fetch_addr loads pc only when a new request launches, i.e. on entry to REQ.
- Arithmetic: 32-bit; pc+4 wraps modulo 2^32. The redirect target loads with bits [1:0] forced to 0; if those bits were nonzero, set misalign.
- Priority each cycle: halt > redirect_valid > stall.

State REQ:
- imem_ready=1 and halt=1: drop the word; ifid_valid<=0; go to HALTED.
- imem_ready=1 and redirect_valid=1: drop the word; pc<=redirect_pc; ifid_valid<=0; stay in REQ, relaunching next cycle.
- imem_ready=1 and stall=1: buffer the word and fetch_addr+4; pc<=fetch_addr+4; go to HOLD. IF/ID is unchanged.
- imem_ready=1 and stall=0: ifid_instr<=imem_rdata; ifid_pc_plus4<=fetch_addr+4; ifid_valid<=1; pc<=fetch_addr+4; relaunch. This gives one instruction per cycle with zero-wait memory.
- imem_ready=0 and redirect_valid=1: pc<=redirect_pc; ifid_valid<=0; go to DRAIN.
- imem_ready=0 and halt=1: go to DRAIN and mark the request halt-pending.
- imem_ready=0 and stall=1: IF/ID is unchanged.
- imem_ready=0 and stall=0: ifid_valid<=0 (bubble).

State HOLD (imem_req=0):
- halt=1: go to HALTED; ifid_valid<=0.
- redirect_valid=1: discard the buffer; pc<=redirect_pc; ifid_valid<=0; go to REQ.
- stall=0: IF/ID<=buffer; ifid_valid<=1; go to REQ.
- stall=1: remain in HOLD.

State DRAIN:
- imem_req stays 1 at the old fetch_addr.
- On imem_ready: discard the data; go to HALTED if halt-pending, else REQ.
- A redirect while in DRAIN overwrites pc (last one wins).
- ifid_valid is held at 0.

State HALTED:
- imem_req=0 and ifid_valid=0.
- Only reset exits this state. redirect and stall are ignored.

Other rules:
- IF/ID is never written while stall=1, except by a redirect or halt clearing ifid_valid.
- A response with imem_ready=1 outside REQ/DRAIN is ignored.
- Reset asserted mid-handshake aborts immediately. After reset, the first request is a fresh launch at RESET_PC.

Decomposition:
- Shared mips.h defines: RESET_PC value, instruction width 32, and fetch state encodings (REQ=2'd0, HOLD=2'd1, DRAIN=2'd2, HALTED=2'd3).
- One natural sub-module: ifid_reg. It holds the IF/ID register with load, hold and invalidate controls, and the decode stage reuses its interface.
- The FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning addr-tagged words -> imem_addr = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; ifid_pc_plus4 = 0x00400004, 0x00400008, ...; ifid_valid=1 from the second cycle.
- imem_ready delayed 3 cycles -> imem_addr stable at 0x00400000 for 4 cycles; ifid_valid=0 during the wait; instr captured on the ready cycle.
- stall high 2 cycles at the ready edge of 0x00400004 -> state HOLD, imem_req=0, IF/ID unchanged; after stall falls, ifid_instr = word@0x00400004, next imem_addr = 0x00400008.
- redirect_pc=0x00400100 while the request to 0x00400008 is outstanding (ready 2 cycles later) -> DRAIN keeps addr 0x00400008; that word is dropped; next request at 0x00400100; ifid_valid=0 until that word arrives.
- redirect_pc=0x00400102 -> misalign=1 sticky; fetch at 0x00400100.
- halt coincident with imem_ready -> word dropped, HALTED, imem_req=0 forever; redirect ignored; rst_n pulse -> fetch resumes at 0x00400000.
